step_ctrl: RTL

//   Parametrised front-panel step controller for board tops. Synchronises the

---
 rtl/step_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/step_ctrl.sv
// Front-panel step controller: reset synchroniser, sampling tick, button debounce and
// instruction latch on a valid/ready handshake. Define STEP_AUTOREPEAT_EN for held-button auto-repeat.
module step_ctrl #(
    parameter int                N_BTN      = 2,
    parameter int                SW_W       = 8,
    parameter int                DIV_W      = 17,
    parameter int                DEB_N      = 3,
    parameter int                CNT_W      = 8,
    parameter logic [N_BTN-1:0]  FORCE_MASK = 2'b10,
    parameter int                RPT_TICKS  = 16
) (
    input  logic              clk,
    input  logic              arst_i,
    input  logic [N_BTN-1:0]  btn_i,
    input  logic [SW_W-1:0]   sw_i,
    input  logic              inst_rdy_i,
    output logic              rst_o,
    output logic              tick_o,
    output logic [SW_W-1:0]   inst_o,
    output logic              inst_vld_o,
    output logic [N_BTN-1:0]  src_o,
    output logic              coll_o,
    output logic [CNT_W-1:0]  cnt_o
);

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [N_BTN-1:0] BTN_ONE = N_BTN'(1'b1);

    logic [1:0]                   rsync_r;
    logic                         srst_s;
    logic [DIV_W-1:0]             div_r;
    logic                         tick_r;
    logic                         tick_d_r;
    logic [N_BTN-1:0][DEB_N-1:0]  sh_r;
    logic [N_BTN-1:0]             raw_rise_s;
    logic [N_BTN-1:0]             rise_s;
    logic [N_BTN-1:0]             win_s;
    logic                         hs_s;
    logic                         acc_s;
    logic                         coll_set_s;
    logic                         force_s;
    logic [SW_W-1:0]              inst_nxt_s;
    logic [SW_W-1:0]              inst_r;
    logic                         inst_vld_r;
    logic [N_BTN-1:0]             src_r;
    logic                         coll_r;
    logic [CNT_W-1:0]             cnt_r;

    // Reset synchroniser: asserts with arst_i, releases on the 2nd clk edge after it drops.
    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            rsync_r <= 2'b11;
        end else begin
            rsync_r <= {rsync_r[0], 1'b0};
        end
    end

    assign srst_s = rsync_r[1];
    assign rst_o  = rsync_r[1];

    // Tick divider with a registered carry and its one-clk delayed copy.
    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            div_r    <= '0;
            tick_r   <= 1'b0;
            tick_d_r <= 1'b0;
        end else if (srst_s) begin
            div_r    <= '0;
            tick_r   <= 1'b0;
            tick_d_r <= 1'b0;
        end else begin
            div_r    <= div_r + DIV_ONE;
            tick_r   <= &div_r;
            tick_d_r <= tick_r;
        end
    end

    // Debounce shift registers: newest sample enters at the top on every tick.
    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            sh_r <= '0;
        end else if (srst_s) begin
            sh_r <= '0;
        end else if (tick_r) begin
            for (int k = 0; k < N_BTN; k++) begin
                sh_r[k] <= {btn_i[k], sh_r[k][DEB_N-1:1]};
            end
        end
    end

    // A press is one old low sample followed by DEB_N-1 high samples.
    always_comb begin
        raw_rise_s = '0;
        for (int k = 0; k < N_BTN; k++) begin
            raw_rise_s[k] = tick_d_r & ~sh_r[k][0] & (&sh_r[k][DEB_N-1:1]);
        end
    end

`ifdef STEP_AUTOREPEAT_EN
    localparam int               RPT_W    = $clog2(RPT_TICKS + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(RPT_TICKS - 1);
    localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1'b1);

    logic [RPT_W-1:0] rpt_r;
    logic             src_held_s;
    logic             rpt_hit_s;

    // The repeat timer only follows the button that produced the current word.
    always_comb begin
        src_held_s = 1'b0;
        for (int k = 0; k < N_BTN; k++) begin
            src_held_s = src_held_s | (src_r[k] & (&sh_r[k]));
        end
    end

    assign rpt_hit_s = tick_d_r & src_held_s & (rpt_r == RPT_LAST);
    assign rise_s    = raw_rise_s | ({N_BTN{rpt_hit_s}} & src_r);

    // Repeat timer: counts held ticks, restarts on accept, release or expiry.
    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            rpt_r <= '0;
        end else if (srst_s) begin
            rpt_r <= '0;
        end else if (acc_s || !src_held_s || rpt_hit_s) begin
            rpt_r <= '0;
        end else if (tick_d_r) begin
            rpt_r <= rpt_r + RPT_ONE;
        end
    end
`else
    logic rpt_unused_s;

    assign rise_s       = raw_rise_s;
    assign rpt_unused_s = (RPT_TICKS > 0);
`endif

    // Lowest-index rise wins; anything else that rose in the same clk is lost.
    assign win_s      = rise_s & (~rise_s + BTN_ONE);
    assign hs_s       = inst_vld_r & inst_rdy_i;
    assign acc_s      = (|rise_s) & (~inst_vld_r | inst_rdy_i);
    assign coll_set_s = ((|rise_s) & ~acc_s) | (|(rise_s & ~win_s));
    assign force_s    = |(win_s & FORCE_MASK);
    assign inst_nxt_s = force_s ? {2'b11, sw_i[SW_W-3:0]} : sw_i;

    // Instruction latch, handshake, collision flag and event counter.
    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            inst_r     <= '0;
            inst_vld_r <= 1'b0;
            src_r      <= '0;
            coll_r     <= 1'b0;
            cnt_r      <= '0;
        end else if (srst_s) begin
            inst_r     <= '0;
            inst_vld_r <= 1'b0;
            src_r      <= '0;
            coll_r     <= 1'b0;
            cnt_r      <= '0;
        end else begin
            if (acc_s) begin
                inst_r     <= inst_nxt_s;
                src_r      <= win_s;
                inst_vld_r <= 1'b1;
            end else if (hs_s) begin
                inst_vld_r <= 1'b0;
            end
            if (hs_s) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            if (coll_set_s) begin
                coll_r <= 1'b1;
            end
        end
    end

    assign tick_o     = tick_r;
    assign inst_o     = inst_r;
    assign inst_vld_o = inst_vld_r;
    assign src_o      = src_r;
    assign coll_o     = coll_r;
    assign cnt_o      = cnt_r;

endmodule
